// File: rtl/hazard_md_ctrl.sv
// hazard_md_ctrl
//   Stall/flush controller for the F/D/E front end. Compares operand demand in
//   D (Tuse) against producer latency (Tnew) in E and M, tracks the M-stage
//   Tnew/A3, and sequences the shared multiply/divide unit with a busy counter.
//
// Ports
//   clk, reset               clock, asynchronous active-high reset
//   D_rs, D_rt               source register fields of the D instruction
//   D_Tuse_rs, D_Tuse_rt     cycles until each operand is needed (3 = unused)
//   D_use_md                 D instruction touches the MDU / HI / LO
//   E_A3, E_Tnew             destination and Tnew of the E instruction
//   E_start, E_is_div        E starts the MDU this cycle; div vs mult select
//   req                      exception/interrupt/eret flush request from M
//   F_en, D_en               PC / FD enables (low while stalling)
//   DE_clr                   insert a bubble into the DE register
//   busy                     MDU busy (combinational)
//   md_done                  registered pulse the cycle after busy falls
//   M_Tnew, M_A3             tracked Tnew/destination of the M instruction
module hazard_md_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic       D_use_md,
  input  logic [4:0] E_A3,
  input  logic [1:0] E_Tnew,
  input  logic       E_start,
  input  logic       E_is_div,
  input  logic       req,
  output logic       F_en,
  output logic       D_en,
  output logic       DE_clr,
  output logic       busy,
  output logic       md_done,
  output logic [1:0] M_Tnew,
  output logic [4:0] M_A3
);

  // The start cycle is itself busy, so the counter only covers the remainder.
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_done_q, md_done_d;
  logic [1:0]       m_tnew_q, m_tnew_d;
  logic [4:0]       m_a3_q, m_a3_d;
  logic             start_ok;
  logic             stall_rs, stall_rt, stall;

  // A start is accepted only from idle; a start while counting is ignored and
  // a flush in the same cycle suppresses it. A running op is never aborted.
  assign start_ok = E_start && !req && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (start_ok)
      cnt_d = E_is_div ? DIV_LD : MULT_LD;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  assign md_done_d = (cnt_q == CNT_W'(1));

  // E->M always advances, even under a stall; the stall only bubbles DE.
  always_comb begin
    m_a3_d   = E_A3;
    m_tnew_d = (E_Tnew == 2'd0) ? 2'd0 : E_Tnew - 2'd1;
    if (req) begin
      m_a3_d   = 5'd0;
      m_tnew_d = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      md_done_q <= 1'b0;
      m_tnew_q  <= 2'd0;
      m_a3_q    <= 5'd0;
    end else begin
      cnt_q     <= cnt_d;
      md_done_q <= md_done_d;
      m_tnew_q  <= m_tnew_d;
      m_a3_q    <= m_a3_d;
    end
  end

  // Tuse=3 can never lose against Tnew<=2, so unused operands never stall.
  assign stall_rs = (D_rs != 5'd0) &&
                    (((E_A3 == D_rs) && (E_Tnew > D_Tuse_rs)) ||
                     ((m_a3_q == D_rs) && (m_tnew_q > D_Tuse_rs)));
  assign stall_rt = (D_rt != 5'd0) &&
                    (((E_A3 == D_rt) && (E_Tnew > D_Tuse_rt)) ||
                     ((m_a3_q == D_rt) && (m_tnew_q > D_Tuse_rt)));

  assign busy  = start_ok || (cnt_q != '0);
  assign stall = stall_rs || stall_rt || (D_use_md && busy);

  assign F_en    = !stall;
  assign D_en    = !stall;
  assign DE_clr  = stall;
  assign md_done = md_done_q;
  assign M_Tnew  = m_tnew_q;
  assign M_A3    = m_a3_q;

endmodule

// File: tb/tb_hazard_md_ctrl.sv
module tb_hazard_md_ctrl;

  logic       clk, reset;
  logic [4:0] D_rs, D_rt, E_A3, M_A3;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic       D_use_md, E_start, E_is_div, req;
  logic       F_en, D_en, DE_clr, busy, md_done;

  int n_chk  = 0;
  int n_fail = 0;

  hazard_md_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_use_md(D_use_md), .E_A3(E_A3), .E_Tnew(E_Tnew),
    .E_start(E_start), .E_is_div(E_is_div), .req(req),
    .F_en(F_en), .D_en(D_en), .DE_clr(DE_clr), .busy(busy),
    .md_done(md_done), .M_Tnew(M_Tnew), .M_A3(M_A3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, want done)");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stall outputs all derive from one expected stall bit.
  task automatic check_stall(input string name, input logic exp_stall);
    check({name, ".DE_clr"}, int'(DE_clr), int'(exp_stall));
    check({name, ".F_en"},   int'(F_en),   int'(!exp_stall));
    check({name, ".D_en"},   int'(D_en),   int'(!exp_stall));
  endtask

  // Inputs change 1ns after the rising edge; checks happen 2ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    D_rs = 0; D_rt = 0; D_Tuse_rs = 3; D_Tuse_rt = 3; D_use_md = 0;
    E_A3 = 0; E_Tnew = 0; E_start = 0; E_is_div = 0; req = 0;
  endtask

  // pre_* is clocked into M first; the remaining fields are then applied.
  typedef struct {
    string      name;
    logic [4:0] pre_a3;
    logic [1:0] pre_tnew;
    logic [4:0] rs, rt;
    logic [1:0] tu_rs, tu_rt;
    logic       use_md;
    logic [4:0] ea3;
    logic [1:0] etnew;
    logic [1:0] exp_mtnew;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[10];

  initial begin
    //            name        pa3 ptn rs rt  trs trt md ea3 etn mtn stall
    vecs[0] = '{"zero_rs",    0,  0,  0, 0,  0,  3,  0, 0,  2,  0,  1'b0};
    vecs[1] = '{"unused_rt",  0,  0,  0, 5,  3,  3,  0, 5,  2,  0,  1'b0};
    vecs[2] = '{"e_rs_haz",   0,  0,  8, 0,  1,  3,  0, 8,  2,  0,  1'b1};
    vecs[3] = '{"e_rs_eq",    0,  0,  8, 0,  2,  3,  0, 8,  2,  0,  1'b0};
    vecs[4] = '{"m_rt_haz",   7,  2,  0, 7,  3,  0,  0, 0,  0,  1,  1'b1};
    vecs[5] = '{"m_rt_eq",    7,  2,  0, 7,  3,  1,  0, 0,  0,  1,  1'b0};
    vecs[6] = '{"m_sat_dec",  7,  0,  0, 7,  3,  0,  0, 0,  0,  0,  1'b0};
    vecs[7] = '{"md_idle",    0,  0,  0, 0,  3,  3,  1, 0,  0,  0,  1'b0};
    vecs[8] = '{"e_a3_diff",  0,  0,  4, 0,  0,  3,  0, 8,  2,  0,  1'b0};
    vecs[9] = '{"m_rs_t2",    6,  1,  6, 0,  0,  3,  0, 0,  0,  0,  1'b0};

    quiet();
    reset = 1'b1;
    #7;
    check("rst.M_Tnew",  int'(M_Tnew),  0);
    check("rst.M_A3",    int'(M_A3),    0);
    check("rst.md_done", int'(md_done), 0);
    check("rst.busy",    int'(busy),    0);
    check_stall("rst", 1'b0);
    #4 reset = 1'b0;
    tick();

    // ---------------- table-driven combinational vectors ----------------
    foreach (vecs[i]) begin
      quiet();
      E_A3 = vecs[i].pre_a3; E_Tnew = vecs[i].pre_tnew;
      tick();
      D_rs = vecs[i].rs; D_rt = vecs[i].rt;
      D_Tuse_rs = vecs[i].tu_rs; D_Tuse_rt = vecs[i].tu_rt;
      D_use_md = vecs[i].use_md; E_A3 = vecs[i].ea3; E_Tnew = vecs[i].etnew;
      #2;
      check({vecs[i].name, ".M_A3"},   int'(M_A3),   int'(vecs[i].pre_a3));
      check({vecs[i].name, ".M_Tnew"}, int'(M_Tnew), int'(vecs[i].exp_mtnew));
      check({vecs[i].name, ".busy"},   int'(busy),   0);
      check_stall(vecs[i].name, vecs[i].exp_stall);
    end

    // ---------------- load-use, Tuse=1: M-stage Tnew=1 no longer stalls ----
    quiet(); tick();
    D_rs = 8; D_Tuse_rs = 1; E_A3 = 8; E_Tnew = 2;
    #2 check_stall("lu1.c0", 1'b1);
    tick();
    E_A3 = 0; E_Tnew = 0;                 // bubble from DE_clr
    #2 check("lu1.c1.M_Tnew", int'(M_Tnew), 1);
    check_stall("lu1.c1", 1'b0);          // 1 > 1 is false

    // ---------------- load-use, Tuse=0: two stall cycles ----------------
    quiet(); tick();
    D_rs = 8; D_Tuse_rs = 0; E_A3 = 8; E_Tnew = 2;
    #2 check_stall("lu0.c0", 1'b1);
    tick();
    E_A3 = 0; E_Tnew = 0;
    #2 check("lu0.c1.M_A3", int'(M_A3), 8);
    check_stall("lu0.c1", 1'b1);
    tick();
    #2 check_stall("lu0.c2", 1'b0);

    // ---------------- mult busy window ----------------
    quiet(); tick();
    D_use_md = 1; E_start = 1; E_is_div = 0;
    for (int c = 0; c <= 6; c++) begin
      #2;
      check($sformatf("mult.c%0d.busy", c),    int'(busy),    int'(c < 5));
      check($sformatf("mult.c%0d.DE_clr", c),  int'(DE_clr),  int'(c < 5));
      check($sformatf("mult.c%0d.md_done", c), int'(md_done), int'(c == 5));
      tick();
      E_start = 0;
    end

    // ---------------- div start suppressed by req ----------------
    quiet(); tick();
    E_start = 1; E_is_div = 1; req = 1;
    #2 check("divreq.c0.busy", int'(busy), 0);
    tick();
    E_start = 0; req = 0;
    #2 check("divreq.c1.busy", int'(busy), 0);
    tick();
    #2 check("divreq.c2.md_done", int'(md_done), 0);

    // ---------------- div with req mid-operation ----------------
    quiet(); tick();
    E_start = 1; E_is_div = 1;
    for (int c = 0; c <= 11; c++) begin
      req = (c == 3);
      #2;
      check($sformatf("div.c%0d.busy", c),    int'(busy),    int'(c <= 9));
      check($sformatf("div.c%0d.md_done", c), int'(md_done), int'(c == 10));
      tick();
      E_start = 0;
    end

    // ---------------- asynchronous reset mid-div ----------------
    quiet(); tick();
    E_start = 1; E_is_div = 1; E_A3 = 4; E_Tnew = 2;
    tick(); E_start = 0;
    tick(); tick(); tick();               // now in cycle 4
    #2 check("arst.pre.M_Tnew", int'(M_Tnew), 1);
    check("arst.pre.busy", int'(busy), 1);
    reset = 1'b1;                          // between edges
    #1;
    check("arst.busy",    int'(busy),    0);
    check("arst.M_Tnew",  int'(M_Tnew),  0);
    check("arst.md_done", int'(md_done), 0);
    check("arst.F_en",    int'(F_en),    1);
    tick();
    reset = 1'b0;
    quiet();
    for (int c = 0; c < 12; c++) begin
      #2 check($sformatf("arst.after%0d.md_done", c), int'(md_done), 0);
      tick();
    end

    // ---------------- M flush by req ----------------
    quiet(); tick();
    E_A3 = 9; E_Tnew = 2; req = 1;
    tick();
    quiet(); D_rs = 9; D_Tuse_rs = 0;
    #2;
    check("mflush.M_A3",   int'(M_A3),   0);
    check("mflush.M_Tnew", int'(M_Tnew), 0);
    check_stall("mflush", 1'b0);
    // same producer without req does reach M and stalls
    quiet(); E_A3 = 9; E_Tnew = 2;
    tick();
    quiet(); D_rs = 9; D_Tuse_rs = 0;
    #2;
    check("mnoflush.M_A3",   int'(M_A3),   9);
    check("mnoflush.M_Tnew", int'(M_Tnew), 1);
    check_stall("mnoflush", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
